// File: rtl/axibram_cmd_ser.sv
// Buffers BRAM-bridge word writes in a FIFO and serializes each {addr,data} as a
// 6-byte frame onto an 8-bit valid/ready command bus, with dev_ready back-pressure.
module axibram_cmd_ser #(
    parameter int ADDRESS_BITS = 10,
    parameter int FIFO_DEPTH   = 16,
    parameter int LEVEL_BITS   = 5
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDRESS_BITS-1:0] bram_waddr,
    input  logic                    bram_wen,
    input  logic [3:0]              bram_wstb,
    input  logic [31:0]             bram_wdata,
    output logic                    dev_ready,
    output logic [7:0]              cmd_ad,
    output logic                    cmd_stb,
    output logic                    cmd_first,
    input  logic                    cmd_ready,
    output logic [LEVEL_BITS-1:0]   fifo_level,
    output logic                    overflow,
    output logic                    partial_wr
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDRESS_BITS + 32;

    typedef enum logic {IDLE, SEND} state_t;

    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [LEVEL_BITS-1:0] level_q, level_d;
    logic                  rst_done_q;
    logic                  overflow_q, partial_q;

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [ENTRY_W-1:0]    hold_q;

    logic push, push_ok, pop, full, empty;

    assign push    = bram_wen && (bram_wstb != 4'h0);
    assign full    = (level_q == LEVEL_BITS'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;

    // Two-entry margin: upstream registers dev_ready, so one more write can land after it falls.
    assign dev_ready  = rst_done_q && (level_q <= LEVEL_BITS'(FIFO_DEPTH - 2));
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign partial_wr = partial_q;

    // Storage needs no reset; validity is tracked by the pointers and level.
    always_ff @(posedge aclk) begin
        if (push_ok) mem_q[wptr_q] <= {bram_waddr, bram_wdata};
    end

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LEVEL_BITS'(1);
            2'b01:   level_d = level_q - LEVEL_BITS'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            rst_done_q <= 1'b0;
            overflow_q <= 1'b0;
            partial_q  <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            level_q    <= level_d;
            if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)     rptr_q <= rptr_q + PTR_W'(1);
            if (push && full)                overflow_q <= 1'b1;
            if (push && bram_wstb != 4'hf)   partial_q  <= 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (pop) hold_q <= mem_q[rptr_q];
        end
    end

    // FSM: next state; a pop on the last accepted byte keeps frames back to back
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cmd_ready) begin
                    if (idx_q == 3'd5) begin
                        idx_d = '0;
                        if (!empty) pop     = 1'b1;
                        else        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    logic [15:0] addr_ext;
    logic [31:0] hold_data;
    assign addr_ext  = 16'(hold_q[ENTRY_W-1:32]);
    assign hold_data = hold_q[31:0];

    always_comb begin
        cmd_stb   = 1'b0;
        cmd_first = 1'b0;
        cmd_ad    = 8'h00;
        if (state_q == SEND) begin
            cmd_stb   = 1'b1;
            cmd_first = (idx_q == 3'd0);
            case (idx_q)
                3'd0:    cmd_ad = addr_ext[7:0];
                3'd1:    cmd_ad = addr_ext[15:8];
                3'd2:    cmd_ad = hold_data[7:0];
                3'd3:    cmd_ad = hold_data[15:8];
                3'd4:    cmd_ad = hold_data[23:16];
                3'd5:    cmd_ad = hold_data[31:24];
                default: cmd_ad = 8'h00;
            endcase
        end
    end

endmodule
